// File: rtl/vga_pkg.sv
// Shared definitions for the text-mode menu: character codes of the glyph ROM,
// the menu FSM state type and a helper that maps a menu row to its number glyph.
// Letter, digit and space codes follow ASCII so label text reads naturally.
package vga_pkg;

  typedef enum logic [0:0] {
    StBrowse = 1'b0,
    StHold   = 1'b1
  } menu_state_e;

  localparam logic [6:0] SPACE  = 7'h20;
  localparam logic [6:0] NKL    = 7'h5B;  // '[' left bracket around the row number
  localparam logic [6:0] NKR    = 7'h5D;  // ']' right bracket around the row number
  localparam logic [6:0] CURSOR = 7'h3E;  // '>' cursor glyph

  localparam logic [6:0] C_0 = 7'h30;
  localparam logic [6:0] C_1 = 7'h31;
  localparam logic [6:0] C_2 = 7'h32;
  localparam logic [6:0] C_3 = 7'h33;
  localparam logic [6:0] C_4 = 7'h34;
  localparam logic [6:0] C_5 = 7'h35;
  localparam logic [6:0] C_6 = 7'h36;
  localparam logic [6:0] C_7 = 7'h37;
  localparam logic [6:0] C_8 = 7'h38;
  localparam logic [6:0] C_9 = 7'h39;

  localparam logic [6:0] CH_A = 7'h41;
  localparam logic [6:0] CH_B = 7'h42;
  localparam logic [6:0] CH_E = 7'h45;
  localparam logic [6:0] CH_F = 7'h46;
  localparam logic [6:0] CH_G = 7'h47;
  localparam logic [6:0] CH_I = 7'h49;
  localparam logic [6:0] CH_J = 7'h4A;
  localparam logic [6:0] CH_L = 7'h4C;
  localparam logic [6:0] CH_N = 7'h4E;
  localparam logic [6:0] CH_O = 7'h4F;
  localparam logic [6:0] CH_R = 7'h52;
  localparam logic [6:0] CH_S = 7'h53;
  localparam logic [6:0] CH_T = 7'h54;
  localparam logic [6:0] CH_U = 7'h55;
  localparam logic [6:0] CH_W = 7'h57;
  localparam logic [6:0] CH_Z = 7'h5A;

  // Number glyph shown for row r is r+1; rows past 9 continue hex-style with letters.
  function automatic logic [6:0] row_digit(input logic [3:0] row);
    if (row < 4'd9) begin
      return C_1 + {3'b000, row};
    end
    return CH_A + {3'b000, row - 4'd9};
  endfunction

endpackage

// File: rtl/menu_label_rom.sv
// Combinational label text table for the menu.
//   row_i  : menu row being fetched
//   col_i  : screen column; labels start at column 4
//   code_o : character code, SPACE outside the label text
module menu_label_rom
  import vga_pkg::*;
(
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output logic [6:0] code_o
);

  always_comb begin
    code_o = SPACE;
    case (row_i)
      4'd0: begin // GRAJ
        case (col_i)
          4'd4:    code_o = CH_G;
          4'd5:    code_o = CH_R;
          4'd6:    code_o = CH_A;
          4'd7:    code_o = CH_J;
          default: code_o = SPACE;
        endcase
      end
      4'd1: begin // FABULA
        case (col_i)
          4'd4:    code_o = CH_F;
          4'd5:    code_o = CH_A;
          4'd6:    code_o = CH_B;
          4'd7:    code_o = CH_U;
          4'd8:    code_o = CH_L;
          4'd9:    code_o = CH_A;
          default: code_o = SPACE;
        endcase
      end
      4'd2: begin // O GRZE
        case (col_i)
          4'd4:    code_o = CH_O;
          4'd5:    code_o = SPACE;
          4'd6:    code_o = CH_G;
          4'd7:    code_o = CH_R;
          4'd8:    code_o = CH_Z;
          4'd9:    code_o = CH_E;
          default: code_o = SPACE;
        endcase
      end
      4'd3: begin // STEROWANIE
        case (col_i)
          4'd4:    code_o = CH_S;
          4'd5:    code_o = CH_T;
          4'd6:    code_o = CH_E;
          4'd7:    code_o = CH_R;
          4'd8:    code_o = CH_O;
          4'd9:    code_o = CH_W;
          4'd10:   code_o = CH_A;
          4'd11:   code_o = CH_N;
          4'd12:   code_o = CH_I;
          4'd13:   code_o = CH_E;
          default: code_o = SPACE;
        endcase
      end
      default: code_o = SPACE;
    endcase
  end

endmodule

// File: rtl/menu_selector.sv
// Text-mode menu: cursor navigation with one action per key press, confirmation pulse,
// blinking highlight of the selected row and a registered glyph lookup for the renderer.
//   clk, rst          : clock and synchronous active-high reset
//   key_up/down/enter : debounced key levels
//   frame_tick        : one-cycle pulse per video frame, drives the blink
//   char_xy           : [7:4] row, [3:0] column of the glyph being fetched
//   char_code/char_hl : glyph code and highlight for char_xy, one cycle later
//   sel_idx           : cursor row
//   choice            : last confirmed row, choice_valid pulses once on confirm
module menu_selector
  import vga_pkg::*;
#(
  parameter int unsigned N_ITEMS      = 4,
  parameter int unsigned COLS         = 16,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       frame_tick,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  output logic       char_hl,
  output logic [3:0] sel_idx,
  output logic [3:0] choice,
  output logic       choice_valid
);

  localparam int unsigned BlinkW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_FRAMES - 1);
  localparam logic [3:0] LastItem = 4'(N_ITEMS - 1);
  localparam logic [4:0] ItemsW   = 5'(N_ITEMS);
  localparam logic [4:0] ColsW    = 5'(COLS);

  menu_state_e       state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        choice_q, choice_d;
  logic              valid_q, valid_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic [6:0]        code_q, code_d;
  logic              hl_q, hl_d;

  logic any_key;
  assign any_key = key_up | key_down | key_enter;

  // Navigation FSM: BROWSE acts on a key, HOLD waits until every key is released.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    choice_d = choice_q;
    valid_d  = 1'b0;
    case (state_q)
      StBrowse: begin
        if (key_enter) begin
          choice_d = sel_q;
          valid_d  = 1'b1;
          state_d  = StHold;
        end else if (key_up && !key_down) begin
          sel_d   = (sel_q == 4'd0) ? LastItem : sel_q - 4'd1;
          state_d = StHold;
        end else if (key_down && !key_up) begin
          sel_d   = (sel_q == LastItem) ? 4'd0 : sel_q + 4'd1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (!any_key) begin
          state_d = StBrowse;
        end
      end
      default: state_d = StBrowse;
    endcase
  end

  // Blink: a cursor move restarts the phase lit, otherwise frames advance the counter.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (sel_d != sel_q) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Glyph lookup
  logic [3:0] row, col;
  logic [6:0] label_code;
  logic       in_range, is_sel;

  assign row = char_xy[7:4];
  assign col = char_xy[3:0];

  menu_label_rom u_label_rom (
    .row_i  (row),
    .col_i  (col),
    .code_o (label_code)
  );

  always_comb begin
    in_range = ({1'b0, row} < ItemsW) && ({1'b0, col} < ColsW);
    is_sel   = (row == sel_q);
    code_d   = SPACE;
    hl_d     = 1'b0;
    if (in_range) begin
      hl_d = is_sel & blink_on_q;
      case (col)
        4'd0:    code_d = NKL;
        4'd1:    code_d = row_digit(row);
        4'd2:    code_d = NKR;
        4'd3:    code_d = is_sel ? CURSOR : SPACE;
        default: code_d = label_code;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBrowse;
      sel_q       <= 4'd0;
      choice_q    <= 4'd0;
      valid_q     <= 1'b0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      code_q      <= SPACE;
      hl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      choice_q    <= choice_d;
      valid_q     <= valid_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      code_q      <= code_d;
      hl_q        <= hl_d;
    end
  end

  assign char_code    = code_q;
  assign char_hl      = hl_q;
  assign sel_idx      = sel_q;
  assign choice       = choice_q;
  assign choice_valid = valid_q;

endmodule

// File: tb/tb_menu_selector.sv
// Bench for menu_selector: directed scenarios plus random keys/frames/fetches,
// all checked against a behavioural model of the menu rules.
module tb_menu_selector;

  localparam int N  = 4;
  localparam int NC = 16;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_up = 1'b0, key_down = 1'b0, key_enter = 1'b0, frame_tick = 1'b0;
  logic [7:0] char_xy = 8'h00;
  logic [6:0] char_code;
  logic       char_hl;
  logic [3:0] sel_idx, choice;
  logic       choice_valid;

  always #5 clk = ~clk;

  menu_selector #(
    .N_ITEMS      (N),
    .COLS         (NC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_enter    (key_enter),
    .frame_tick   (frame_tick),
    .char_xy      (char_xy),
    .char_code    (char_code),
    .char_hl      (char_hl),
    .sel_idx      (sel_idx),
    .choice       (choice),
    .choice_valid (choice_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: cursor, confirmed choice, press lock and frames since the last cursor move.
  string labels[4] = '{"GRAJ", "FABULA", "O GRZE", "STEROWANIE"};
  int   m_sel = 0, m_choice = 0, m_frames = 0;
  bit   m_valid = 0, m_locked = 0, m_hl = 0;
  logic [6:0] m_code = 7'h20;

  function automatic bit model_blink(input int frames);
    return ((frames / BF) % 2) == 0;
  endfunction

  task automatic model_lookup(input int row, input int col, output logic [6:0] code,
                              output bit hl);
    string s;
    code = 7'h20;
    hl   = 0;
    if (row < N && col < NC) begin
      hl = (row == m_sel) && model_blink(m_frames);
      if (col == 0) code = 7'h5B;
      else if (col == 1) code = 7'(8'h30 + row + 1);
      else if (col == 2) code = 7'h5D;
      else if (col == 3) code = (row == m_sel) ? 7'h3E : 7'h20;
      else if (row < 4) begin
        s = labels[row];
        if (col - 4 < s.len()) code = 7'(s.getc(col - 4));
      end
    end
  endtask

  task automatic model_edge();
    int nsel;
    if (rst) begin
      m_sel = 0; m_choice = 0; m_valid = 0; m_locked = 0; m_frames = 0;
      m_code = 7'h20; m_hl = 0;
      return;
    end
    model_lookup(int'(char_xy[7:4]), int'(char_xy[3:0]), m_code, m_hl);
    m_valid = 0;
    nsel = m_sel;
    if (!m_locked) begin
      if (key_enter) begin
        m_choice = m_sel; m_valid = 1; m_locked = 1;
      end else if (key_up && !key_down) begin
        nsel = (m_sel + N - 1) % N; m_locked = 1;
      end else if (key_down && !key_up) begin
        nsel = (m_sel + 1) % N; m_locked = 1;
      end
    end else if (!key_up && !key_down && !key_enter) begin
      m_locked = 0;
    end
    if (nsel != m_sel) m_frames = 0;
    else if (frame_tick) m_frames++;
    m_sel = nsel;
  endtask

  task automatic step(input logic r, input logic u, input logic d, input logic e,
                      input logic t, input logic [7:0] xy);
    rst = r; key_up = u; key_down = d; key_enter = e; frame_tick = t; char_xy = xy;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("sel_idx", 32'(sel_idx), 32'(m_sel));
    check_eq("choice", 32'(choice), 32'(m_choice));
    check_eq("choice_valid", 32'(choice_valid), 32'(m_valid));
    check_eq("char_code", 32'(char_code), 32'(m_code));
    check_eq("char_hl", 32'(char_hl), 32'(m_hl));
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 0, 8'h00);
    check_eq("rst_sel", 32'(sel_idx), 32'd0);
    check_eq("rst_code", 32'(char_code), 32'h20);
    check_eq("rst_hl", 32'(char_hl), 32'd0);

    // Row 0 glyphs, one-cycle latency, highlighted after reset
    step(0, 0, 0, 0, 0, 8'h00);
    check_eq("r38_nkl", 32'(char_code), 32'h5B);
    check_eq("r38_hl0", 32'(char_hl), 32'd1);
    step(0, 0, 0, 0, 0, 8'h01);
    check_eq("r38_c1", 32'(char_code), 32'h31);
    step(0, 0, 0, 0, 0, 8'h03);
    check_eq("r38_cursor", 32'(char_code), 32'h3E);
    step(0, 0, 0, 0, 0, 8'h04);
    check_eq("r38_g", 32'(char_code), 32'h47);
    check_eq("r38_hl3", 32'(char_hl), 32'd1);

    // Held key acts once
    step(0, 0, 1, 0, 0, 8'h00);
    step(0, 0, 1, 0, 0, 8'h13);
    check_eq("r39_cursor13", 32'(char_code), 32'h3E);
    step(0, 0, 1, 0, 0, 8'h00);
    check_eq("r39_once", 32'(sel_idx), 32'd1);
    step(0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 0, 8'h00);
    check_eq("r39_second", 32'(sel_idx), 32'd2);
    step(0, 0, 0, 0, 0, 8'h00);

    // Wrap both ways
    step(1, 0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 0, 8'h00);
    check_eq("r40_wrap_up", 32'(sel_idx), 32'd3);
    step(0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 0, 8'h00);
    check_eq("r40_wrap_down", 32'(sel_idx), 32'd0);
    step(0, 0, 0, 0, 0, 8'h00);

    // Enter wins over up/down
    step(0, 0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 8'h00);
    step(0, 1, 1, 1, 0, 8'h00);
    check_eq("r41_choice", 32'(choice), 32'd2);
    check_eq("r41_valid", 32'(choice_valid), 32'd1);
    step(0, 1, 1, 1, 0, 8'h00);
    check_eq("r41_pulse_end", 32'(choice_valid), 32'd0);
    check_eq("r41_sel", 32'(sel_idx), 32'd2);
    step(0, 0, 0, 0, 0, 8'h20);

    // Blink pattern on the selected row
    step(0, 0, 0, 0, 1, 8'h20);
    check_eq("r42_hl_a", 32'(char_hl), 32'd1);
    step(0, 0, 0, 0, 1, 8'h20);
    check_eq("r42_hl_b", 32'(char_hl), 32'd1);
    step(0, 0, 0, 0, 1, 8'h20);
    check_eq("r42_hl_c", 32'(char_hl), 32'd0);
    step(0, 0, 0, 0, 1, 8'h20);
    check_eq("r42_hl_d", 32'(char_hl), 32'd0);
    step(0, 0, 0, 0, 1, 8'h20);
    step(0, 0, 0, 0, 1, 8'h20);
    step(0, 0, 1, 0, 0, 8'h20);
    check_eq("r42_dark", 32'(char_hl), 32'd0);
    step(0, 0, 0, 0, 0, 8'h30);
    check_eq("r42_move_lit", 32'(char_hl), 32'd1);
    step(0, 0, 0, 0, 0, 8'h50);
    check_eq("r42_oob_code", 32'(char_code), 32'h20);
    check_eq("r42_oob_hl", 32'(char_hl), 32'd0);

    // Reset during HOLD with key held
    step(0, 0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 0, 8'h00);
    step(1, 0, 1, 0, 0, 8'h00);
    check_eq("r43_in_rst", 32'(sel_idx), 32'd0);
    step(0, 0, 1, 0, 0, 8'h00);
    check_eq("r43_after", 32'(sel_idx), 32'd1);
    step(0, 0, 0, 0, 0, 8'h00);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] xy;
      xy = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) == 0),
           xy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
